// File: rtl/life_array_grid_pkg.sv
// Shared Game-of-Life constants, FSM encodings and the cell update rule.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package life_array_grid_pkg;

  localparam int LIFE_BIRTH   = 3;
  localparam int LIFE_SURVIVE = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A cell lives next generation on exactly BIRTH neighbours, or SURVIVE if already alive.
  function automatic logic life_rule(input logic cur, input logic [3:0] cnt);
    return (cnt == 4'(LIFE_BIRTH)) || (cur && (cnt == 4'(LIFE_SURVIVE)));
  endfunction

endpackage

// File: rtl/life_array_grid_cell.sv
// One Game-of-Life cell: neighbour count, rule and state flop with load/shift/advance.
// Latency: new state visible one clk after load, shift or adv.
// Backpressure: none; priority is load > shift > adv.
module life_array_grid_cell
  import life_array_grid_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] nbr,
  input  logic       load,
  input  logic       load_val,
  input  logic       shift,
  input  logic       shift_in,
  input  logic       adv,
  output logic       alive,
  output logic       nxt
);

  logic [3:0] cnt;

  // Count live neighbours and apply the rule to get the candidate next state.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, nbr[i]};
    end
    nxt = life_rule(alive, cnt);
  end

  // State flop: parallel load wins over scan shift, which wins over evolution.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive <= 1'b0;
    end else if (load) begin
      alive <= load_val;
    end else if (shift) begin
      alive <= shift_in;
    end else if (adv) begin
      alive <= nxt;
    end
  end

endmodule

// File: rtl/life_array_grid.sv
// ROWSxCOLS Game-of-Life tile with optional torus wrap, scan chain, step/run FSM and status.
// Latency: one generation per advancing clk; loads and shifts take effect on the next edge.
// Backpressure: none; write_enb > scan_en > advance, and any load parks the FSM in IDLE.
module life_array_grid
  import life_array_grid_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int WRAP  = 0,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] val,
  input  logic                 write_enb,
  input  logic                 scan_en,
  input  logic                 scan_in,
  output logic                 scan_out,
  input  logic                 run,
  input  logic                 step,
  input  logic [GEN_W-1:0]     gen_limit,
  input  logic [COLS-1:0]      n,
  input  logic [COLS-1:0]      s,
  input  logic [ROWS-1:0]      w,
  input  logic [ROWS-1:0]      e,
  input  logic                 nw,
  input  logic                 ne,
  input  logic                 se,
  input  logic                 sw,
  output logic [ROWS*COLS-1:0] alive,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 done,
  output logic                 still,
  output logic                 empty
);

  localparam int N = ROWS * COLS;

  state_t           state_q;
  state_t           state_d;
  logic             load_any;
  logic             advance;
  logic             limit_hit;
  logic [GEN_W-1:0] gen_inc;
  logic [N-1:0]     next_alive;
  logic [N-1:0]     shift_src;
  // Grid framed by a one-cell halo: [0] and [ROWS+1]/[COLS+1] are the off-grid neighbours.
  logic             ext [0:ROWS+1][0:COLS+1];

  assign load_any  = write_enb | scan_en;
  assign gen_inc   = gen_count + GEN_W'(1);
  assign limit_hit = (gen_limit != '0) && (gen_inc == gen_limit);
  assign shift_src = {scan_in, alive[N-1:1]};
  assign scan_out  = alive[0];
  assign empty     = ~|alive;

  // Build the halo: either wrapped copies of the opposite edge or the stitching ports.
  always_comb begin
    ext = '{default: 1'b0};
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        ext[r+1][c+1] = alive[c*ROWS + r];
      end
    end
    if (WRAP != 0) begin
      for (int c = 0; c < COLS; c++) begin
        ext[0][c+1]      = alive[c*ROWS + ROWS - 1];
        ext[ROWS+1][c+1] = alive[c*ROWS];
      end
      for (int r = 0; r < ROWS; r++) begin
        ext[r+1][0]      = alive[(COLS-1)*ROWS + r];
        ext[r+1][COLS+1] = alive[r];
      end
      ext[0][0]           = alive[N-1];
      ext[0][COLS+1]      = alive[ROWS-1];
      ext[ROWS+1][0]      = alive[(COLS-1)*ROWS];
      ext[ROWS+1][COLS+1] = alive[0];
    end else begin
      for (int c = 0; c < COLS; c++) begin
        ext[0][c+1]      = n[c];
        ext[ROWS+1][c+1] = s[c];
      end
      for (int r = 0; r < ROWS; r++) begin
        ext[r+1][0]      = w[r];
        ext[r+1][COLS+1] = e[r];
      end
      ext[0][0]           = nw;
      ext[0][COLS+1]      = ne;
      ext[ROWS+1][0]      = sw;
      ext[ROWS+1][COLS+1] = se;
    end
  end

  // Cell array, column-major with row 0 at the north edge; the scan chain runs toward index 0.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      life_array_grid_cell u_cell (
        .clk      (clk),
        .reset    (reset),
        .nbr      ({ext[r][c],   ext[r][c+1],   ext[r][c+2],
                    ext[r+1][c],                ext[r+1][c+2],
                    ext[r+2][c], ext[r+2][c+1], ext[r+2][c+2]}),
        .load     (write_enb),
        .load_val (val[c*ROWS + r]),
        .shift    (scan_en),
        .shift_in (shift_src[c*ROWS + r]),
        .adv      (advance),
        .alive    (alive[c*ROWS + r]),
        .nxt      (next_alive[c*ROWS + r])
      );
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: loads abort to IDLE; dropping run always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (load_any) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (run) state_d = ST_RUN;
        ST_RUN: begin
          if (!run) begin
            state_d = ST_IDLE;
          end else if (limit_hit) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: if (!run) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: RUN advances every cycle, IDLE only on step, DONE never; loads suppress it.
  always_comb begin
    advance = 1'b0;
    if (!load_any) begin
      advance = (state_q == ST_RUN) || ((state_q == ST_IDLE) && step);
    end
    done = (state_q == ST_DONE);
  end

  // Generation counter and still flag restart on any load and update on every advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gen_count <= '0;
      still     <= 1'b0;
    end else if (load_any) begin
      gen_count <= '0;
      still     <= 1'b0;
    end else if (advance) begin
      gen_count <= gen_inc;
      still     <= (next_alive == alive);
    end
  end

endmodule

// File: tb/tb_life_array_grid.sv
// Self-checking bench: a 4x4 edge-port tile and a 5x5 torus tile against a behavioural life model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_life_array_grid;

  localparam int GR = 4;
  localparam int GC = 4;
  localparam int GN = GR * GC;
  localparam int TR = 5;
  localparam int TC = 5;
  localparam int TN = TR * TC;
  localparam int GW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  // 4x4, edge ports live
  logic [GN-1:0] g_val;
  logic          g_write, g_scan, g_sin, g_run, g_step;
  logic [GW-1:0] g_limit;
  logic [GC-1:0] g_n, g_s;
  logic [GR-1:0] g_w, g_e;
  logic          g_nw, g_ne, g_se, g_sw;
  logic          g_sout;
  logic [GN-1:0] g_alive;
  logic [GW-1:0] g_gen;
  logic          g_done, g_still, g_empty;

  // 5x5 torus
  logic [TN-1:0] t_val;
  logic          t_write, t_scan, t_sin, t_run, t_step;
  logic [GW-1:0] t_limit;
  logic [TC-1:0] t_n, t_s;
  logic [TR-1:0] t_w, t_e;
  logic          t_nw, t_ne, t_se, t_sw;
  logic          t_sout;
  logic [TN-1:0] t_alive;
  logic [GW-1:0] t_gen;
  logic          t_done, t_still, t_empty;

  life_array_grid #(.ROWS(GR), .COLS(GC), .WRAP(0), .GEN_W(GW)) u_grid (
    .clk(clk), .reset(reset), .val(g_val), .write_enb(g_write), .scan_en(g_scan),
    .scan_in(g_sin), .scan_out(g_sout), .run(g_run), .step(g_step), .gen_limit(g_limit),
    .n(g_n), .s(g_s), .w(g_w), .e(g_e), .nw(g_nw), .ne(g_ne), .se(g_se), .sw(g_sw),
    .alive(g_alive), .gen_count(g_gen), .done(g_done), .still(g_still), .empty(g_empty)
  );

  life_array_grid #(.ROWS(TR), .COLS(TC), .WRAP(1), .GEN_W(GW)) u_torus (
    .clk(clk), .reset(reset), .val(t_val), .write_enb(t_write), .scan_en(t_scan),
    .scan_in(t_sin), .scan_out(t_sout), .run(t_run), .step(t_step), .gen_limit(t_limit),
    .n(t_n), .s(t_s), .w(t_w), .e(t_e), .nw(t_nw), .ne(t_ne), .se(t_se), .sw(t_sw),
    .alive(t_alive), .gen_count(t_gen), .done(t_done), .still(t_still), .empty(t_empty)
  );

  // Reference generation: cor = {sw, se, ne, nw}
  function automatic logic [63:0] life_next(input logic [63:0] g, input int rows, input int cols,
                                            input bit wrap, input logic [7:0] pn, input logic [7:0] ps,
                                            input logic [7:0] pw, input logic [7:0] pe,
                                            input logic [3:0] cor);
    logic [63:0] nx;
    nx = '0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              int rr, cc;
              rr = r + dr;
              cc = c + dc;
              if (wrap) begin
                rr = (rr + rows) % rows;
                cc = (cc + cols) % cols;
                cnt += int'(g[cc*rows + rr]);
              end else if (rr >= 0 && rr < rows && cc >= 0 && cc < cols) cnt += int'(g[cc*rows + rr]);
              else if (rr < 0 && cc < 0)         cnt += int'(cor[0]);
              else if (rr < 0 && cc >= cols)     cnt += int'(cor[1]);
              else if (rr >= rows && cc >= cols) cnt += int'(cor[2]);
              else if (rr >= rows && cc < 0)     cnt += int'(cor[3]);
              else if (rr < 0)                   cnt += int'(pn[cc]);
              else if (rr >= rows)               cnt += int'(ps[cc]);
              else if (cc < 0)                   cnt += int'(pw[rr]);
              else                               cnt += int'(pe[rr]);
            end
          end
        end
        nx[c*rows + r] = (cnt == 3) || (cnt == 2 && g[c*rows + r]);
      end
    end
    return nx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    checks++; if (g_alive !== '0) begin errors++; $display("FAIL reset_alive: got %h expected 0", g_alive); end
    checks++; if (g_gen !== '0) begin errors++; $display("FAIL reset_gen: got %0d expected 0", g_gen); end
    checks++; if (g_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", g_done); end
    checks++; if (g_still !== 1'b0) begin errors++; $display("FAIL reset_still: got %b expected 0", g_still); end
    checks++; if (g_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", g_empty); end
    checks++; if (t_alive !== '0) begin errors++; $display("FAIL reset_torus_alive: got %h expected 0", t_alive); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_blinker();
    g_val = 16'h0070; g_write = 1'b1; tick(); g_write = 1'b0;
    checks++; if (g_alive !== 16'h0070) begin errors++; $display("FAIL blinker_load: got %h expected 0070", g_alive); end
    g_step = 1'b1; tick(); g_step = 1'b0;
    checks++; if (g_alive !== 16'h0222) begin errors++; $display("FAIL blinker_step: got %h expected 0222", g_alive); end
    checks++; if (g_gen !== 16'd1) begin errors++; $display("FAIL blinker_gen: got %0d expected 1", g_gen); end
    tick();
    checks++; if (g_alive !== 16'h0222) begin errors++; $display("FAIL blinker_idle_hold: got %h expected 0222", g_alive); end
    g_step = 1'b1; tick();
    checks++; if (g_alive !== 16'h0070 || g_gen !== 16'd2) begin errors++; $display("FAIL step_held_1: got %h/%0d expected 0070/2", g_alive, g_gen); end
    tick(); g_step = 1'b0;
    checks++; if (g_alive !== 16'h0222 || g_gen !== 16'd3) begin errors++; $display("FAIL step_held_2: got %h/%0d expected 0222/3", g_alive, g_gen); end
  endtask

  task automatic test_scan();
    logic [15:0] pat;
    logic [63:0] ex;
    pat = 16'hA5C3;
    g_scan = 1'b1;
    for (int i = 0; i < 16; i++) begin
      g_sin = pat[i];
      tick();
    end
    checks++; if (g_alive !== pat) begin errors++; $display("FAIL scan_load: got %h expected %h", g_alive, pat); end
    checks++; if (g_gen !== '0) begin errors++; $display("FAIL scan_gen_clear: got %0d expected 0", g_gen); end
    for (int i = 0; i < 16; i++) exp_q.push_back({63'd0, pat[i]});
    g_sin = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ex = exp_q.pop_front();
      checks++; if (g_sout !== ex[0]) begin errors++; $display("FAIL scan_out bit %0d: got %b expected %b", i, g_sout, ex[0]); end
      tick();
    end
    g_scan = 1'b0;
    checks++; if (g_alive !== '0) begin errors++; $display("FAIL scan_unload_zero: got %h expected 0", g_alive); end
  endtask

  task automatic test_block();
    g_val = 16'h0660; g_write = 1'b1; tick(); g_write = 1'b0;
    g_run = 1'b1; repeat (3) tick(); g_run = 1'b0; tick();
    checks++; if (g_alive !== 16'h0660) begin errors++; $display("FAIL block_alive: got %h expected 0660", g_alive); end
    checks++; if (g_still !== 1'b1) begin errors++; $display("FAIL block_still: got %b expected 1", g_still); end
    checks++; if (g_gen !== 16'd3) begin errors++; $display("FAIL block_gen: got %0d expected 3", g_gen); end
    checks++; if (g_done !== 1'b0) begin errors++; $display("FAIL block_done: got %b expected 0", g_done); end
    g_val = '0; g_write = 1'b1; tick(); g_write = 1'b0;
    checks++; if (g_empty !== 1'b1) begin errors++; $display("FAIL zero_empty: got %b expected 1", g_empty); end
    checks++; if (g_still !== 1'b0) begin errors++; $display("FAIL zero_still_clear: got %b expected 0", g_still); end
  endtask

  task automatic test_edge_ports();
    logic [63:0] model;
    logic [63:0] ex;
    g_n = 4'b0111; g_step = 1'b1; tick(); g_step = 1'b0; g_n = '0;
    checks++; if (g_alive !== 16'h0010) begin errors++; $display("FAIL edge_north_birth: got %h expected 0010", g_alive); end
    checks++; if (g_empty !== 1'b0) begin errors++; $display("FAIL edge_empty: got %b expected 0", g_empty); end
    model = {48'd0, 16'($urandom)};
    g_val = model[15:0]; g_write = 1'b1; tick(); g_write = 1'b0;
    g_step = 1'b1;
    for (int k = 0; k < 12; k++) begin
      g_n = 4'($urandom); g_s = 4'($urandom); g_w = 4'($urandom); g_e = 4'($urandom);
      g_nw = 1'($urandom); g_ne = 1'($urandom); g_se = 1'($urandom); g_sw = 1'($urandom);
      model = life_next(model, GR, GC, 1'b0, {4'd0, g_n}, {4'd0, g_s}, {4'd0, g_w}, {4'd0, g_e},
                        {g_sw, g_se, g_ne, g_nw});
      exp_q.push_back(model);
      tick();
      ex = exp_q.pop_front();
      checks++; if (g_alive !== ex[GN-1:0]) begin errors++; $display("FAIL edge_random gen %0d: got %h expected %h", k + 1, g_alive, ex[GN-1:0]); end
    end
    g_step = 1'b0;
    g_n = '0; g_s = '0; g_w = '0; g_e = '0; g_nw = 1'b0; g_ne = 1'b0; g_se = 1'b0; g_sw = 1'b0;
    checks++; if (g_gen !== 16'd12) begin errors++; $display("FAIL edge_random_gen: got %0d expected 12", g_gen); end
  endtask

  task automatic test_glider();
    logic [TN-1:0] start;
    logic [63:0]   model;
    logic [63:0]   ex;
    logic          want_done;
    start = 25'h00018A4;
    t_val = start; t_write = 1'b1; tick(); t_write = 1'b0;
    model = {39'd0, start};
    t_limit = 16'd20; t_run = 1'b1; tick();
    checks++; if (t_alive !== start || t_gen !== '0) begin errors++; $display("FAIL glider_enter_run: got %h/%0d expected %h/0", t_alive, t_gen, start); end
    for (int k = 1; k <= 20; k++) begin
      model = life_next(model, TR, TC, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 4'd0);
      exp_q.push_back(model);
      tick();
      ex = exp_q.pop_front();
      want_done = (k == 20);
      checks++; if (t_alive !== ex[TN-1:0]) begin errors++; $display("FAIL glider gen %0d: got %h expected %h", k, t_alive, ex[TN-1:0]); end
      checks++; if (t_gen !== 16'(k)) begin errors++; $display("FAIL glider_gen_count %0d: got %0d", k, t_gen); end
      checks++; if (t_done !== want_done) begin errors++; $display("FAIL glider_done %0d: got %b expected %b", k, t_done, want_done); end
    end
    repeat (3) tick();
    checks++; if (t_alive !== start) begin errors++; $display("FAIL glider_home: got %h expected %h", t_alive, start); end
    checks++; if (t_gen !== 16'd20 || t_done !== 1'b1) begin errors++; $display("FAIL glider_hold: got %0d/%b expected 20/1", t_gen, t_done); end
    t_run = 1'b0; tick();
    checks++; if (t_done !== 1'b0 || t_gen !== 16'd20) begin errors++; $display("FAIL glider_release: got %b/%0d expected 0/20", t_done, t_gen); end
  endtask

  task automatic test_back_to_back();
    g_val = 16'h0070; g_write = 1'b1; tick(); g_write = 1'b0;
    g_run = 1'b1; tick(); tick();
    checks++; if (g_alive !== 16'h0222 || g_gen !== 16'd1) begin errors++; $display("FAIL b2b_running: got %h/%0d expected 0222/1", g_alive, g_gen); end
    g_val = 16'h0070; g_write = 1'b1; g_scan = 1'b1; g_sin = 1'b1; tick();
    g_write = 1'b0; g_scan = 1'b0; g_sin = 1'b0;
    checks++; if (g_alive !== 16'h0070 || g_gen !== '0) begin errors++; $display("FAIL b2b_load_wins: got %h/%0d expected 0070/0", g_alive, g_gen); end
    tick();
    checks++; if (g_alive !== 16'h0070 || g_gen !== '0) begin errors++; $display("FAIL b2b_reenter: got %h/%0d expected 0070/0", g_alive, g_gen); end
    tick();
    checks++; if (g_alive !== 16'h0222 || g_gen !== 16'd1) begin errors++; $display("FAIL b2b_resume: got %h/%0d expected 0222/1", g_alive, g_gen); end
  endtask

  task automatic test_reset_mid();
    tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (g_alive !== '0 || g_gen !== '0) begin errors++; $display("FAIL reset_async: got %h/%0d expected 0/0", g_alive, g_gen); end
    g_run = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++; if (g_alive !== '0 || g_still !== 1'b0 || g_done !== 1'b0) begin errors++; $display("FAIL reset_release: got %h/%b/%b expected 0/0/0", g_alive, g_still, g_done); end
  endtask

  initial begin
    reset = 1'b0;
    g_val = '0; g_write = 1'b0; g_scan = 1'b0; g_sin = 1'b0; g_run = 1'b0; g_step = 1'b0; g_limit = '0;
    g_n = '0; g_s = '0; g_w = '0; g_e = '0; g_nw = 1'b0; g_ne = 1'b0; g_se = 1'b0; g_sw = 1'b0;
    t_val = '0; t_write = 1'b0; t_scan = 1'b0; t_sin = 1'b0; t_run = 1'b0; t_step = 1'b0; t_limit = '0;
    t_n = '0; t_s = '0; t_w = '0; t_e = '0; t_nw = 1'b0; t_ne = 1'b0; t_se = 1'b0; t_sw = 1'b0;
    test_reset();
    test_blinker();
    test_scan();
    test_block();
    test_edge_ports();
    test_glider();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
